card_datapath: RTL and testbench
================================

// Module: card_datapath
// PURPOSE
//  Datapath side of the baccarat round: responds to the load_pcard*/load_dcard* strobes from the round FSM.
//  - Card source: internal free-running card counter (1..13).
//  - Storage: latches dealt cards into six card registers.
//  - Scores back to the FSM: pscore, dscore and pcard3, computed from the registered cards.
//  - Display: drives the six HEX displays.
// PARAMETERS
//  SEED      4'd1   card counter value after reset; legal range 1..13
//  CARD_MAX  4'd13  highest card code before the counter wraps to 1
// PORTS
//  slow_clock    in   1  single clock; all state updates on rising edge
//  resetb        in   1  asynchronous, active-low reset
//  load_pcard1   in   1  capture current card into player card 1
//  load_pcard2   in   1  capture current card into player card 2
//  load_pcard3   in   1  capture current card into player card 3
//  load_dcard1   in   1  capture current card into dealer card 1
//  load_dcard2   in   1  capture current card into dealer card 2
//  load_dcard3   in   1  capture current card into dealer card 3
//  pcard3        out  4  registered player card 3 code (0 = not dealt)
//  pscore        out  4  player hand score 0..9
//  dscore        out  4  dealer hand score 0..9
//  cards_dealt   out  3  count of card loads since reset, saturates at 6
//  HEX0..HEX2    out  7  active-low segments for pcard1..pcard3
//  HEX3..HEX5    out  7  active-low segments for dcard1..dcard3
// BEHAVIOUR
//  Reset (resetb=0, asynchronous, takes effect immediately, also mid-round):
//   - all six card registers = 0; pcard3 = 0; pscore = 0; dscore = 0
//   - cards_dealt = 0; card counter = SEED; HEX0..HEX5 = 7'b1111111 (blank)
//  Card counter:
//   - advances every edge while resetb=1: 1 -> 2 -> ... -> CARD_MAX -> 1
//   - advances regardless of load activity; never holds 0, 14 or 15
//  Card loads:
//   - on an edge with load_X=1, register X takes the counter value present before that edge's increment
//   - a loaded card is visible on outputs one cycle after the strobe is sampled (registered)
//   - a load with load_X=0 leaves register X unchanged
//   - re-asserting a load overwrites the register (no lockout)
//   - simultaneous loads: every asserted register captures the same card value
//  cards_dealt:
//   - += popcount of the asserted load_* strobes that edge
//   - saturates at 6, no wrap
//  Card value (combinational, per register):
//   - code 1..9 -> value = code; codes 0 and 10..13 -> value 0
//  Scores (combinational from registers, no added latency):
//   - pscore = (v(pc1)+v(pc2)+v(pc3)) mod 10; dscore likewise for dc1..dc3
//   - sum held in 5 bits (max 27); result truncated to 4 bits after mod
//  pcard3: direct copy of player card 3 register.
//  HEX (active-low, decoded per register):
//   - 0 = blank; 1 = "A"; 2..9 = digits; 10 = "0"; 11 = "J"; 12 = "q"; 13 = "K"
//   - codes 14, 15 cannot occur in a register; if forced, display blank
// STRUCTURE
//  - baccarat_pkg: card_t (logic [3:0]); constants CARD_NONE=0, CARD_ACE=1, CARD_KING=13;
//    the HEX segment patterns (SEG_BLANK, SEG_A, SEG_0..SEG_9, SEG_J, SEG_Q, SEG_K)
//  - card7seg: combinational card_t -> 7-bit segment decoder, instantiated 6x
//  - card_datapath: counter, six card registers, cards_dealt, score adders
// TESTING
//  1. Basic deal (SEED=1):
//     - release reset; assert load_pcard1, load_dcard1, load_pcard2, load_dcard2 one per cycle
//     - -> cards 1, 2, 3, 4; pscore=4, dscore=6
//     - -> HEX0=SEG_A; cards_dealt=4
//  2. Face cards and mod-10:
//     - idle until counter=10; load_pcard1 at 10, load_pcard2 at 11
//     - -> pscore=0, HEX0=SEG_0, HEX1=SEG_J
//     - SEED=7, pc1/pc2/pc3 on consecutive edges -> 7, 8, 9; pscore 5 then 4; pcard3=9
//  3. Counter wrap:
//     - idle 13 cycles after reset, then load_dcard1
//     - -> dcard1=1 (wrapped 13 -> 1); no 0 or 14 ever captured
//  4. Simultaneous and saturating loads:
//     - assert all six loads on one edge while counter=5
//     - -> every register = 5; pscore=dscore=5; cards_dealt=6
//     - a further load keeps cards_dealt=6
//  5. Reset mid-round:
//     - drop resetb between edges after 3 loads
//     - -> registers, scores and cards_dealt = 0 and HEX all 7'b1111111 before the next edge
//     - counter = SEED
//  6. Overwrite:
//     - load_pcard1 at counter 2, then again at counter 6 -> pcard1=6; pscore=6; cards_dealt=2

Source files
------------

// File: rtl/baccarat_pkg.sv
// Shared card types, card codes and 7-segment glyphs for the baccarat datapath.
// Segment vectors are active-low, bit order {g,f,e,d,c,b,a}.
package baccarat_pkg;

    typedef logic [3:0] card_t;

    localparam card_t CARD_NONE = 4'd0;
    localparam card_t CARD_ACE  = 4'd1;
    localparam card_t CARD_KING = 4'd13;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_J     = 7'b1100001;
    localparam logic [6:0] SEG_Q     = 7'b0011000;
    localparam logic [6:0] SEG_K     = 7'b0001001;

    // Baccarat point value: tens and face cards count zero.
    function automatic logic [3:0] card_value(input card_t c);
        if (c >= 4'd1 && c <= 4'd9) begin
            card_value = c;
        end else begin
            card_value = 4'd0;
        end
    endfunction

    // Hand score of three cards, modulo 10.
    function automatic logic [3:0] hand_score(input card_t a,
                                              input card_t b,
                                              input card_t c);
        logic [4:0] sum;
        logic [4:0] m;
        sum = {1'b0, card_value(a)} + {1'b0, card_value(b)}
            + {1'b0, card_value(c)};
        m = sum % 5'd10;
        hand_score = m[3:0];
    endfunction

endpackage

// File: rtl/card7seg.sv
// Combinational card code to active-low 7-segment glyph decoder.
// Ports: card (4-bit card code in), seg (7-bit active-low segments out).
module card7seg
    import baccarat_pkg::*;
(
    input  logic [3:0] card,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (card)
            4'd1:    seg = SEG_A;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            4'd10:   seg = SEG_0;
            4'd11:   seg = SEG_J;
            4'd12:   seg = SEG_Q;
            4'd13:   seg = SEG_K;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/card_datapath.sv
// Baccarat round datapath: card counter, six card registers, deal count,
// hand scores and HEX display drive.
// Ports: slow_clock/resetb (clock, async active-low reset); load_pcard1..3,
// load_dcard1..3 (capture strobes); pcard3, pscore, dscore (to round FSM);
// cards_dealt (saturating load count); HEX0..HEX5 (active-low segments).
module card_datapath
    import baccarat_pkg::*;
#(
    parameter logic [3:0] SEED     = 4'd1,
    parameter logic [3:0] CARD_MAX = 4'd13
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [2:0] cards_dealt,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    card_t      cnt_q, cnt_d;
    card_t      card_q [6];
    card_t      card_d [6];
    logic [2:0] dealt_q, dealt_d;
    logic [5:0] load;
    logic [6:0] hex [6];

    // Index order: 0..2 player cards, 3..5 dealer cards.
    assign load = {load_dcard3, load_dcard2, load_dcard1,
                   load_pcard3, load_pcard2, load_pcard1};

    always_comb begin
        // Out-of-range values also fold back to 1 so 0/14/15 never persist.
        if (cnt_q >= CARD_MAX || cnt_q == CARD_NONE) begin
            cnt_d = CARD_ACE;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            card_d[i] = card_q[i];
            if (load[i]) begin
                card_d[i] = cnt_q;
            end
        end
    end

    always_comb begin
        logic [3:0] sum;
        sum = {1'b0, dealt_q};
        for (int i = 0; i < 6; i++) begin
            sum = sum + {3'b000, load[i]};
        end
        dealt_d = (sum > 4'd6) ? 3'd6 : sum[2:0];
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            cnt_q   <= SEED;
            dealt_q <= 3'd0;
            for (int i = 0; i < 6; i++) begin
                card_q[i] <= CARD_NONE;
            end
        end else begin
            cnt_q   <= cnt_d;
            dealt_q <= dealt_d;
            for (int i = 0; i < 6; i++) begin
                card_q[i] <= card_d[i];
            end
        end
    end

    assign pcard3      = card_q[2];
    assign cards_dealt = dealt_q;
    assign pscore      = hand_score(card_q[0], card_q[1], card_q[2]);
    assign dscore      = hand_score(card_q[3], card_q[4], card_q[5]);

    for (genvar g = 0; g < 6; g++) begin : g_seg
        card7seg u_seg (
            .card (card_q[g]),
            .seg  (hex[g])
        );
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];

endmodule

// File: tb/tb_card_datapath.sv
// Directed self-checking bench for card_datapath (SEED=1 and SEED=7 instances).
// Expected values come from hand-computed constants and a tracked counter model.
module tb_card_datapath;
    import baccarat_pkg::*;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic [5:0] ld = '0;
    logic [2:0] ld7 = '0;

    logic [3:0] pcard3, pscore, dscore;
    logic [2:0] cards_dealt;
    logic [6:0] h0, h1, h2, h3, h4, h5;

    logic [3:0] pcard3_7, pscore_7, dscore_7;
    logic [2:0] dealt_7;
    logic [6:0] g0, g1, g2, g3, g4, g5;

    int nchk = 0;
    int nerr = 0;
    int mc;

    always #5 clk = ~clk;

    card_datapath u_dut (
        .slow_clock  (clk),
        .resetb      (resetb),
        .load_pcard1 (ld[0]),
        .load_pcard2 (ld[1]),
        .load_pcard3 (ld[2]),
        .load_dcard1 (ld[3]),
        .load_dcard2 (ld[4]),
        .load_dcard3 (ld[5]),
        .pcard3      (pcard3),
        .pscore      (pscore),
        .dscore      (dscore),
        .cards_dealt (cards_dealt),
        .HEX0        (h0),
        .HEX1        (h1),
        .HEX2        (h2),
        .HEX3        (h3),
        .HEX4        (h4),
        .HEX5        (h5)
    );

    card_datapath #(.SEED(4'd7)) u_dut7 (
        .slow_clock  (clk),
        .resetb      (resetb),
        .load_pcard1 (ld7[0]),
        .load_pcard2 (ld7[1]),
        .load_pcard3 (ld7[2]),
        .load_dcard1 (1'b0),
        .load_dcard2 (1'b0),
        .load_dcard3 (1'b0),
        .pcard3      (pcard3_7),
        .pscore      (pscore_7),
        .dscore      (dscore_7),
        .cards_dealt (dealt_7),
        .HEX0        (g0),
        .HEX1        (g1),
        .HEX2        (g2),
        .HEX3        (g3),
        .HEX4        (g4),
        .HEX5        (g5)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One edge with the given strobes; inputs change 1 time unit after edges.
    task automatic tick(input logic [5:0] l, input logic [2:0] l7);
        ld  = l;
        ld7 = l7;
        @(posedge clk);
        #1;
        ld  = '0;
        ld7 = '0;
        mc  = (mc == 13) ? 1 : mc + 1;
    endtask

    task automatic idle_until(input int v);
        for (int i = 0; i < 20 && mc != v; i++) begin
            tick(6'b0, 3'b0);
        end
        chk("idle_reach", 8'(mc), 8'(v));
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        #1;
        mc = 1;
        resetb = 1'b1;
    endtask

    task automatic chk_blank(input string tag);
        chk(tag, {1'b0, h0 & h1 & h2 & h3 & h4 & h5}, {1'b0, SEG_BLANK});
        chk(tag, {1'b0, h0 | h1 | h2 | h3 | h4 | h5}, {1'b0, SEG_BLANK});
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state
        chk("rst_pcard3", 8'(pcard3), 8'd0);
        chk("rst_pscore", 8'(pscore), 8'd0);
        chk("rst_dscore", 8'(dscore), 8'd0);
        chk("rst_dealt", 8'(cards_dealt), 8'd0);
        chk_blank("rst_hex");
        do_reset();

        // Basic deal: cards 1,2,3,4
        tick(6'b000001, 3'b0);
        tick(6'b001000, 3'b0);
        tick(6'b000010, 3'b0);
        tick(6'b010000, 3'b0);
        chk("t1_pscore", 8'(pscore), 8'd4);
        chk("t1_dscore", 8'(dscore), 8'd6);
        chk("t1_hex0", 8'(h0), 8'(SEG_A));
        chk("t1_hex1", 8'(h1), 8'(SEG_3));
        chk("t1_hex3", 8'(h3), 8'(SEG_2));
        chk("t1_hex4", 8'(h4), 8'(SEG_4));
        chk("t1_hex2", 8'(h2), 8'(SEG_BLANK));
        chk("t1_pcard3", 8'(pcard3), 8'd0);
        chk("t1_dealt", 8'(cards_dealt), 8'd4);

        // Face cards and mod 10
        idle_until(10);
        tick(6'b000001, 3'b0);
        tick(6'b000010, 3'b0);
        chk("t2_pscore", 8'(pscore), 8'd0);
        chk("t2_hex0", 8'(h0), 8'(SEG_0));
        chk("t2_hex1", 8'(h1), 8'(SEG_J));
        tick(6'b000100, 3'b0);
        chk("t2_pcard3", 8'(pcard3), 8'd12);
        chk("t2_hex2", 8'(h2), 8'(SEG_Q));
        chk("t2_sat", 8'(cards_dealt), 8'd6);
        tick(6'b100000, 3'b0);
        chk("t2_hex5", 8'(h5), 8'(SEG_K));
        chk("t2_dscore", 8'(dscore), 8'd6);

        // SEED=7 instance: 7, 8, 9
        do_reset();
        tick(6'b0, 3'b001);
        chk("s7_ps1", 8'(pscore_7), 8'd7);
        tick(6'b0, 3'b010);
        chk("s7_ps2", 8'(pscore_7), 8'd5);
        tick(6'b0, 3'b100);
        chk("s7_ps3", 8'(pscore_7), 8'd4);
        chk("s7_pcard3", 8'(pcard3_7), 8'd9);
        chk("s7_hex0", 8'(g0), 8'(SEG_7));
        chk("s7_dealt", 8'(dealt_7), 8'd3);

        // Counter wrap: 13 idle edges then dcard1 gets 1
        do_reset();
        for (int i = 0; i < 13; i++) begin
            tick(6'b0, 3'b0);
        end
        tick(6'b001000, 3'b0);
        chk("t3_hex3", 8'(h3), 8'(SEG_A));
        chk("t3_dscore", 8'(dscore), 8'd1);
        chk("t3_dealt", 8'(cards_dealt), 8'd1);
        // 13 is captured, then 1 again right after
        idle_until(13);
        tick(6'b000100, 3'b0);
        chk("t3_p3_13", 8'(pcard3), 8'd13);
        tick(6'b000100, 3'b0);
        chk("t3_p3_1", 8'(pcard3), 8'd1);

        // Simultaneous loads at counter 5
        do_reset();
        idle_until(5);
        tick(6'b111111, 3'b0);
        chk("t4_pscore", 8'(pscore), 8'd5);
        chk("t4_dscore", 8'(dscore), 8'd5);
        chk("t4_pcard3", 8'(pcard3), 8'd5);
        chk("t4_dealt", 8'(cards_dealt), 8'd6);
        chk("t4_hex0", 8'(h0), 8'(SEG_5));
        chk("t4_hex5", 8'(h5), 8'(SEG_5));
        tick(6'b000001, 3'b0);
        chk("t4_sat", 8'(cards_dealt), 8'd6);
        chk("t4_ps_ovw", 8'(pscore), 8'd6);

        // Reset mid-round
        do_reset();
        tick(6'b000001, 3'b0);
        tick(6'b000100, 3'b0);
        tick(6'b001000, 3'b0);
        chk("t5_pre_dealt", 8'(cards_dealt), 8'd3);
        chk("t5_pre_p3", 8'(pcard3), 8'd2);
        #2;
        resetb = 1'b0;
        #1;
        chk("t5_pscore", 8'(pscore), 8'd0);
        chk("t5_dscore", 8'(dscore), 8'd0);
        chk("t5_pcard3", 8'(pcard3), 8'd0);
        chk("t5_dealt", 8'(cards_dealt), 8'd0);
        chk_blank("t5_hex");
        mc = 1;
        resetb = 1'b1;
        tick(6'b000100, 3'b0);
        chk("t5_seed", 8'(pcard3), 8'd1);

        // Overwrite: pcard1 at 2 then at 6
        do_reset();
        tick(6'b0, 3'b0);
        tick(6'b000001, 3'b0);
        chk("t6_first", 8'(h0), 8'(SEG_2));
        idle_until(6);
        tick(6'b000001, 3'b0);
        chk("t6_hex0", 8'(h0), 8'(SEG_6));
        chk("t6_pscore", 8'(pscore), 8'd6);
        chk("t6_dealt", 8'(cards_dealt), 8'd2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
